cla_subtractor_pipe: RTL and testbench
======================================

// Module: cla_subtractor_pipe
// PURPOSE
//  Pipelined WIDTH-bit subtractor built from 4-bit borrow-lookahead slices, one slice per stage.
//  Computes diff = a - b - bin with borrow-out, signed-overflow and zero flags.
//  Valid/ready handshake on both sides; sits beside the 4-bit carry-lookahead adder as its inverse datapath.
// PARAMETERS
//  WIDTH   16   operand width; must be a multiple of 4 and >= 8
//  NSLICE  WIDTH/4  derived (localparam); number of slice stages
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand valid
//  in_ready   out  1      unit can accept operands this cycle
//  a          in   WIDTH  minuend (unsigned or two's complement)
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//  bout       out  1      borrow out: 1 when a < b + bin (unsigned)
//  ovf        out  1      signed overflow
//  zero       out  1      diff == 0
// BEHAVIOUR
//  - Reset: all valid bits 0, all data regs 0; out_valid=0, diff=0, bout=0, ovf=0, zero=0; in_ready=1.
//  - advance = !out_valid || out_ready; in_ready = advance. Whole pipe moves or stalls together.
//  - Transfer in on edge with in_valid && in_ready; transfer out on edge with out_valid && out_ready.
//  - Stage 0 registers a, b, bin, valid. Stage k (1..NSLICE) computes nibble k-1 from stage k-1 borrow;
//    upper operand nibbles and finished diff nibbles ride along. Outputs driven from stage NSLICE regs.
//  - Latency: result on diff/out_valid NSLICE+1 edges after acceptance (WIDTH=16 -> 5). Throughput 1/cycle.
//  - Slice math per bit i: g=~a&b, p=~(a^b); b[i+1]=g|p&b[i]; d=a^b^b[i]; 4-bit lookahead, no ripple.
//  - bout = borrow out of MSB slice. ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]). zero from final diff.
//  - Bubbles (valid=0) propagate; data regs of bubble stages may hold stale values, flags gated by valid.
//  - Stall: while out_valid && !out_ready, every stage holds; diff/flags stable; in_ready=0.
//  - Simultaneous out transfer and in acceptance in one cycle is legal (no lost slot).
//  - Order preserved; no result dropped or duplicated.
//  - Reset mid-operation: in-flight results discarded immediately (async); nothing emitted after release
//    until new operands accepted.
// CONFIGURATION
//  CLA_SUB_ADD_MODE_EN defined: extra input port op (1 bit, sampled with operands, piped with them).
//    op=0 subtract as above. op=1: diff=(a+b+bin) mod 2^WIDTH, bout=carry out,
//    ovf=(a[MSB]==b[MSB]) && (diff[MSB]!=a[MSB]); slices use carry lookahead g=a&b, p=a^b.
//  Not defined: no op port; subtract only; identical latency and handshake.
// TESTING  (WIDTH=16, out_ready=1 unless noted)
//  1. a=0x0005 b=0x0003 bin=0 -> 5 edges later diff=0x0002 bout=0 ovf=0 zero=0.
//  2. a=0x0000 b=0x0001 bin=0 -> diff=0xFFFF bout=1 ovf=0 zero=0.
//  3. a=0x8000 b=0x0001 bin=0 -> diff=0x7FFF bout=0 ovf=1; a=0x1234 b=0x1233 bin=1 -> diff=0 zero=1.
//  4. 8 back-to-back ops; out_ready=0 for 3 cycles after first out_valid -> in_ready=0 those cycles,
//     outputs held stable, all 8 results emitted in order, none lost.
//  5. rst_n low with 3 ops in flight -> out_valid=0 and outputs 0 at once; no stale result after release.
//  6. CLA_SUB_ADD_MODE_EN: op=1 a=0xFFFF b=0x0001 bin=0 -> diff=0x0000 bout=1 zero=1 ovf=0;
//     op=1 a=0x7FFF b=0x0001 -> diff=0x8000 ovf=1.

Source files
------------

// File: rtl/cla_subtractor_pipe.sv
// cla_subtractor_pipe: pipelined a-b-bin built from 4-bit borrow-lookahead slices, one slice per stage.
// Optional CLA_SUB_ADD_MODE_EN adds port i_op (1 = add with carry lookahead) carried with the operands.
module cla_subtractor_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_bin,
`ifdef CLA_SUB_ADD_MODE_EN
   input  logic             i_op,
`endif
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_bout,
   output logic             o_ovf,
   output logic             o_zero
);
   localparam int NSLICE = WIDTH / 4;

   logic             r_v   [0:NSLICE];
   logic             r_sub [0:NSLICE];
   logic             r_c   [0:NSLICE];
   logic [WIDTH-1:0] r_a   [0:NSLICE];
   logic [WIDTH-1:0] r_b   [0:NSLICE];
   logic [WIDTH-1:0] r_d   [0:NSLICE];
   logic [4:0]       w_s   [1:NSLICE];
   logic             w_adv;
   logic             w_sub_in;

`ifdef CLA_SUB_ADD_MODE_EN
   assign w_sub_in = ~i_op;
`else
   assign w_sub_in = 1'b1;
`endif

   // Inverting a turns carry lookahead (g=a&b, p=a^b) into borrow lookahead (g=~a&b, p=~(a^b)).
   function automatic logic [4:0] f_slice(input logic [3:0] a, input logic [3:0] b,
                                          input logic c0, input logic sub);
      logic [3:0] g, p, x;
      logic [4:0] c;
      x = a ^ {4{sub}};
      g = x & b;
      p = x ^ b;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], a ^ b ^ c[3:0]};
   endfunction

   always_comb begin
      for (int k = 1; k <= NSLICE; k++)
         w_s[k] = f_slice(r_a[k-1][4*(k-1) +: 4], r_b[k-1][4*(k-1) +: 4], r_c[k-1], r_sub[k-1]);
   end

   assign w_adv      = ~r_v[NSLICE] | i_out_ready;
   assign o_in_ready = w_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= NSLICE; k++) begin
            r_v[k]   <= 1'b0;
            r_sub[k] <= 1'b0;
            r_c[k]   <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_d[k]   <= '0;
         end
      end else if (w_adv) begin
         r_v[0]   <= i_in_valid;
         r_sub[0] <= w_sub_in;
         r_c[0]   <= i_bin;
         r_a[0]   <= i_a;
         r_b[0]   <= i_b;
         r_d[0]   <= '0;
         for (int k = 1; k <= NSLICE; k++) begin
            r_v[k]   <= r_v[k-1];
            r_sub[k] <= r_sub[k-1];
            r_c[k]   <= w_s[k][4];
            r_a[k]   <= r_a[k-1];
            r_b[k]   <= r_b[k-1];
            r_d[k]   <= r_d[k-1];
            r_d[k][4*(k-1) +: 4] <= w_s[k][3:0];
         end
      end
   end

   assign o_out_valid = r_v[NSLICE];
   assign o_diff      = r_d[NSLICE];
   assign o_bout      = r_v[NSLICE] & r_c[NSLICE];
   assign o_zero      = r_v[NSLICE] & (r_d[NSLICE] == '0);
   assign o_ovf       = r_v[NSLICE]
                      & (r_a[NSLICE][WIDTH-1] ^ r_b[NSLICE][WIDTH-1] ^ ~r_sub[NSLICE])
                      & (r_d[NSLICE][WIDTH-1] ^ r_a[NSLICE][WIDTH-1]);
endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// tb_cla_subtractor_pipe: directed table, stall/reset sequences and random traffic
// checked against an arithmetic reference model with an in-order scoreboard.
module tb_cla_subtractor_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0, b = '0;
   logic        bin = 1'b0;
   logic        op = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] diff;
   logic        bout, ovf, zero;

   int n_vec = 0;
   int n_err = 0;
   int n_out = 0;
   logic [18:0] q[$];

   typedef struct {
      logic [15:0] a, b;
      logic        bin, op;
      logic [15:0] d;
      logic        bo, ov, z;
   } vec_t;
   vec_t tv[$];

   cla_subtractor_pipe #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_a(a), .i_b(b), .i_bin(bin),
`ifdef CLA_SUB_ADD_MODE_EN
      .i_op(op),
`endif
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_diff(diff), .o_bout(bout), .o_ovf(ovf), .o_zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: {bout, ovf, zero, diff} from plain integer arithmetic.
   function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic add);
      logic [16:0] t;
      int s;
      if (add) begin
         t = {1'b0, x} + {1'b0, y} + 17'(c);
         s = int'($signed(x)) + int'($signed(y)) + int'(c);
      end else begin
         t = {1'b0, x} - {1'b0, y} - 17'(c);
         s = int'($signed(x)) - int'($signed(y)) - int'(c);
      end
      return {t[16], (s > 32767 || s < -32768), t[15:0] == 16'h0, t[15:0]};
   endfunction

   always @(negedge clk) begin
      if (in_valid && in_ready) q.push_back(model(a, b, bin, op));
      if (out_valid && out_ready) begin
         n_out++;
         if (q.size() == 0) chk("unexpected_result", 32'(out_valid), 32'(0));
         else chk("scoreboard", 32'({bout, ovf, zero, diff}), 32'(q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      int base;
      logic [15:0] held;
      logic [18:0] e;
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, base;
      logic [18:0] held;
      tv.push_back('{16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0});
      tv.push_back('{16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0});
      tv.push_back('{16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0});
      tv.push_back('{16'h1234, 16'h1233, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
      tv.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0});
      tv.push_back('{16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0});
      tv.push_back('{16'hABCD, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
`ifdef CLA_SUB_ADD_MODE_EN
      tv.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1});
      tv.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0});
`endif
      // Reset state
      repeat (2) tick();
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_outputs", 32'({bout, ovf, zero, diff}), 32'(0));
      rst_n = 1'b1;
      tick();
      // Directed table with latency check
      foreach (tv[i]) begin
         a = tv[i].a; b = tv[i].b; bin = tv[i].bin; op = tv[i].op; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         cnt = 1;
         while (!out_valid && cnt < 20) begin tick(); cnt++; end
         chk($sformatf("latency[%0d]", i), 32'(cnt), 32'(5));
         chk($sformatf("vec[%0d]", i), 32'({bout, ovf, zero, diff}),
             32'({tv[i].bo, tv[i].ov, tv[i].z, tv[i].d}));
         tick();
      end
      op = 1'b0;
      // Eight back-to-back ops with a three-cycle output stall
      base = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); in_valid = 1'b1;
               cnt = 0;
               do begin @(negedge clk); cnt++; end while (!in_ready && cnt < 50);
               tick();
            end
            in_valid = 1'b0;
         end
         begin
            cnt = 0;
            while (!out_valid && cnt < 50) begin tick(); cnt++; end
            out_ready = 1'b0;
            held = {bout, ovf, zero, diff};
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(in_ready), 32'(0));
               chk("stall_out_valid", 32'(out_valid), 32'(1));
               chk("stall_hold", 32'({bout, ovf, zero, diff}), 32'(held));
               tick();
            end
            out_ready = 1'b1;
         end
      join
      cnt = 0;
      while (q.size() != 0 && cnt < 50) begin tick(); cnt++; end
      chk("stall_drain", 32'(q.size()), 32'(0));
      chk("stall_count", 32'(n_out - base), 32'(8));
      // Randomized traffic with random back-pressure
      base = n_out;
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         if (in_valid && in_ready) cnt++;
         in_valid = ($urandom % 4) != 0;
         a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
`ifdef CLA_SUB_ADD_MODE_EN
         op = 1'($urandom);
`endif
         out_ready = ($urandom % 4) != 0;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (20) tick();
      chk("random_drain", 32'(q.size()), 32'(0));
      op = 1'b0;
      // Reset with three ops in flight
      for (int i = 0; i < 3; i++) begin
         a = 16'(i + 7); b = 16'(i); bin = 1'b0; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      chk("midrst_outputs", 32'({bout, ovf, zero, diff}), 32'(0));
      chk("midrst_in_ready", 32'(in_ready), 32'(1));
      q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      cnt = 0;
      repeat (10) begin tick(); if (out_valid) cnt++; end
      chk("post_rst_no_stale", 32'(cnt), 32'(0));
      a = 16'h0005; b = 16'h0003; bin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cnt = 1;
      while (!out_valid && cnt < 20) begin tick(); cnt++; end
      chk("post_rst_result", 32'({out_valid, bout, ovf, zero, diff}), 32'({1'b1, 19'h00002}));
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
